// File: rtl/opb_pkg.sv
// Shared definitions for the OPB single-beat master: FSM states, response codes and bus widths.
package opb_pkg;

  localparam int OPB_AWIDTH = 32;
  localparam int OPB_DWIDTH = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    XFER    = 3'd2,
    BACKOFF = 3'd3,
    RESP    = 3'd4
  } opb_state_e;

  localparam logic [1:0] STAT_OK    = 2'b00;
  localparam logic [1:0] STAT_ERR   = 2'b01;
  localparam logic [1:0] STAT_TOUT  = 2'b10;
  localparam logic [1:0] STAT_RETRY = 2'b11;

endpackage

// File: rtl/opb_single_master.sv
// OPB initiator: turns a valid/ready command into one single-beat OPB read or write
// and returns a one-cycle response strobe with read data and completion status.
module opb_single_master
  import opb_pkg::*;
#(
  parameter int C_OPB_AWIDTH = OPB_AWIDTH,
  parameter int C_OPB_DWIDTH = OPB_DWIDTH,
  parameter int C_MAX_RETRY  = 8
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]     cmd_addr,
  input  logic [C_OPB_DWIDTH-1:0]     cmd_wdata,
  input  logic [C_OPB_DWIDTH/8-1:0]   cmd_be,
  output logic                        rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]     rsp_rdata,
  output logic [1:0]                  rsp_status,
  output logic                        M_request,
  output logic                        M_busLock,
  output logic                        M_select,
  output logic                        M_RNW,
  output logic [0:C_OPB_AWIDTH-1]     M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
  output logic [0:C_OPB_DWIDTH-1]     M_DBus,
  output logic                        M_seqAddr,
  input  logic                        OPB_MGrant,
  input  logic                        OPB_xferAck,
  input  logic                        OPB_errAck,
  input  logic                        OPB_retry,
  input  logic                        OPB_timeout,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus
);

  localparam int               BE_W        = C_OPB_DWIDTH / 8;
  localparam logic [7:0]       MAX_RETRY_C = 8'(C_MAX_RETRY);

  opb_state_e                  state_r, state_nxt_s;
  logic [7:0]                  retry_cnt_r, retry_cnt_nxt_s, retry_inc_s;
  logic                        rnw_r;
  logic [C_OPB_AWIDTH-1:0]     addr_r;
  logic [C_OPB_DWIDTH-1:0]     wdata_r;
  logic [BE_W-1:0]             be_r;
  logic                        accept_s;

  logic                        cmd_ready_r, ready_nxt_s;
  logic                        rsp_valid_r, rsp_valid_nxt_s;
  logic [C_OPB_DWIDTH-1:0]     rsp_rdata_r, rsp_rdata_nxt_s;
  logic [1:0]                  rsp_status_r, rsp_status_nxt_s;
  logic                        m_request_r, request_nxt_s;
  logic                        m_select_r, drive_bus_s;
  logic                        m_rnw_r, rnw_nxt_s;
  logic [C_OPB_AWIDTH-1:0]     m_abus_r, abus_nxt_s;
  logic [BE_W-1:0]             m_be_r, be_nxt_s;
  logic [C_OPB_DWIDTH-1:0]     m_dbus_r, dbus_nxt_s;

  assign accept_s    = cmd_valid && cmd_ready_r;
  assign retry_inc_s = retry_cnt_r + 8'd1;

  // Command latch: captured once per accepted command, held for the whole transaction.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rnw_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      be_r    <= '0;
    end else if (accept_s) begin
      rnw_r   <= cmd_rnw;
      addr_r  <= cmd_addr;
      wdata_r <= cmd_wdata;
      be_r    <= cmd_be;
    end
  end

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_nxt_s      = state_r;
    retry_cnt_nxt_s  = retry_cnt_r;
    ready_nxt_s      = 1'b0;
    request_nxt_s    = 1'b0;
    drive_bus_s      = 1'b0;
    rsp_valid_nxt_s  = 1'b0;
    rsp_status_nxt_s = STAT_OK;
    rsp_rdata_nxt_s  = '0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s     = REQ;
          request_nxt_s   = 1'b1;
          retry_cnt_nxt_s = 8'd0;
        end else begin
          ready_nxt_s = 1'b1;
        end
      end
      REQ: begin
        if (OPB_MGrant) begin
          state_nxt_s = XFER;
          drive_bus_s = 1'b1;
        end else begin
          request_nxt_s = 1'b1;
        end
      end
      XFER: begin
        // Terminations are prioritised errAck > timeout > retry > xferAck.
        if (OPB_errAck) begin
          state_nxt_s      = RESP;
          rsp_valid_nxt_s  = 1'b1;
          rsp_status_nxt_s = STAT_ERR;
        end else if (OPB_timeout) begin
          state_nxt_s      = RESP;
          rsp_valid_nxt_s  = 1'b1;
          rsp_status_nxt_s = STAT_TOUT;
        end else if (OPB_retry) begin
          retry_cnt_nxt_s = retry_inc_s;
          if (retry_inc_s == MAX_RETRY_C) begin
            state_nxt_s      = RESP;
            rsp_valid_nxt_s  = 1'b1;
            rsp_status_nxt_s = STAT_RETRY;
          end else begin
            state_nxt_s = BACKOFF;
          end
        end else if (OPB_xferAck) begin
          state_nxt_s      = RESP;
          rsp_valid_nxt_s  = 1'b1;
          rsp_status_nxt_s = STAT_OK;
          rsp_rdata_nxt_s  = rnw_r ? C_OPB_DWIDTH'(OPB_DBus) : '0;
        end else begin
          drive_bus_s = 1'b1;
        end
      end
      BACKOFF: begin
        state_nxt_s   = REQ;
        request_nxt_s = 1'b1;
      end
      RESP: begin
        state_nxt_s = IDLE;
        ready_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
        ready_nxt_s = 1'b1;
      end
    endcase
    rnw_nxt_s  = drive_bus_s ? rnw_r : 1'b0;
    abus_nxt_s = drive_bus_s ? addr_r : '0;
    be_nxt_s   = drive_bus_s ? be_r : '0;
    dbus_nxt_s = (drive_bus_s && !rnw_r) ? wdata_r : '0;
  end

  // State, retry counter and output registers.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_r      <= IDLE;
      retry_cnt_r  <= 8'd0;
      cmd_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= '0;
      rsp_status_r <= STAT_OK;
      m_request_r  <= 1'b0;
      m_select_r   <= 1'b0;
      m_rnw_r      <= 1'b0;
      m_abus_r     <= '0;
      m_be_r       <= '0;
      m_dbus_r     <= '0;
    end else begin
      state_r      <= state_nxt_s;
      retry_cnt_r  <= retry_cnt_nxt_s;
      cmd_ready_r  <= ready_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
      rsp_rdata_r  <= rsp_rdata_nxt_s;
      rsp_status_r <= rsp_status_nxt_s;
      m_request_r  <= request_nxt_s;
      m_select_r   <= drive_bus_s;
      m_rnw_r      <= rnw_nxt_s;
      m_abus_r     <= abus_nxt_s;
      m_be_r       <= be_nxt_s;
      m_dbus_r     <= dbus_nxt_s;
    end
  end

  // Internal vectors are numeric [N-1:0]; OPB buses put the MSB at index 0.
  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign rsp_status = rsp_status_r;
  assign M_request  = m_request_r;
  assign M_busLock  = 1'b0;
  assign M_select   = m_select_r;
  assign M_RNW      = m_rnw_r;
  assign M_ABus     = m_abus_r;
  assign M_BE       = m_be_r;
  assign M_DBus     = m_dbus_r;
  assign M_seqAddr  = 1'b0;

endmodule
